axi_stream_pattern_source: RTL
==============================

AXI_STREAM_PATTERN_SOURCE -- requirements
Module: axi_stream_pattern_source

Interface
REQ-001 Parameter DATA_W, default 32: stream data width in bits.
REQ-002 Parameter LEN_W, default 8: frame length field width; the maximum frame length is 2^LEN_W-1 beats.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  the reset; synchronous, active-high.
REQ-005 start  input  1  frame request, sampled only in IDLE.
REQ-006 seed  input  DATA_W  first data word of the frame, latched on an accepted start.
REQ-007 length  input  LEN_W  beats per frame, latched on an accepted start.
REQ-008 gap  input  4  idle cycles inserted between beats, latched on an accepted start.
REQ-009 busy  output  1  high while a frame is in progress (states SEND, GAP).
REQ-010 done  output  1  one-cycle pulse on frame completion.
REQ-011 m_axis_tdata  output  DATA_W  stream data to the downstream data mover.
REQ-012 m_axis_tvalid  output  1  stream valid.
REQ-013 m_axis_tready  input  1  stream ready from downstream.
REQ-014 m_axis_tlast  output  1  high with the final beat of a frame.

Function
REQ-015 The block SHALL implement the FSM states IDLE, SEND and GAP; all outputs SHALL be registered.
REQ-016 IDLE: busy=0, m_axis_tvalid=0; start=1 with length!=0 SHALL latch seed/length/gap, clear the beat counter and enter SEND on the same edge.
REQ-017 Latency: start sampled at edge k SHALL make m_axis_tvalid=1 and m_axis_tdata=seed visible from edge k to edge k+1.
REQ-018 start with length=0 SHALL be ignored (no busy, no valid, no done).
REQ-019 start while busy=1 SHALL be ignored; latched parameters SHALL NOT change mid-frame.
REQ-020 SEND: m_axis_tvalid=1; a beat SHALL transfer only on an edge where m_axis_tvalid && m_axis_tready.
REQ-021 While m_axis_tvalid=1 and m_axis_tready=0, tdata, tlast and tvalid SHALL hold stable; valid SHALL NOT drop before the handshake.
REQ-022 m_axis_tvalid SHALL NOT depend combinationally on m_axis_tready.
REQ-023 Each successive beat's data SHALL be the previous data + 1, modulo 2^DATA_W (FFFFFFFF wraps to 00000000).
REQ-024 m_axis_tlast SHALL be 1 exactly while the beat count equals length-1 and m_axis_tvalid=1.
REQ-025 On a non-final handshake: gap=0 SHALL stay in SEND with the next word presented immediately (one beat per cycle sustained); gap=G>0 SHALL enter GAP with m_axis_tvalid=0 for exactly G cycles, then return to SEND.
REQ-026 On the final handshake: next state IDLE, m_axis_tvalid=0, busy=0 and done=1 for exactly one cycle.
REQ-027 start asserted during the done cycle SHALL be accepted (back-to-back frames, no dead cycle beyond done).
REQ-028 The beat counter SHALL be LEN_W bits; a frame of length 2^LEN_W-1 SHALL complete without overflow.

Reset
REQ-029 With reset=1 at an edge, the block SHALL enter IDLE, with busy=0, done=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0 and the counters cleared.
REQ-030 Reset SHALL take priority over start and over any handshake in the same cycle.
REQ-031 Reset mid-frame SHALL abort the frame: no done pulse, and no further beats until a new start.

Verification
REQ-032 seed=ABCDEEFF, length=3, gap=0, tready=1 -> beats ABCDEEFF, ABCDEF00, ABCDEF01 on 3 consecutive cycles; tlast on the third; done the next cycle.
REQ-033 seed=DCBA0000, length=2, tready=0 for 5 cycles then 1 -> tvalid=1 and tdata=DCBA0000 held for all 5 stalled cycles; then DCBA0000 accepted, followed by DCBA0001 with tlast.
REQ-034 length=3, gap=2, tready=1 -> valid pattern 1,0,0,1,0,0,1; then done.
REQ-035 seed=FFFFFFFF, length=2 -> beats FFFFFFFF then 00000000 (tlast).
REQ-036 length=0 start -> no activity; start pulse while busy -> frame unchanged; start in done cycle -> new frame tvalid on the next cycle.
REQ-037 reset=1 after the 2nd beat of a length=5 frame -> tvalid=0 and busy=0 after the edge; done never asserts.

Source files
------------

// File: rtl/axi_stream_pattern_source_if.sv
// ---------------------------------------------------------------------------
// axi_stream_pattern_source_if
// Purpose : AXI4-Stream style bundle (data, valid, last, ready) carried
//           between the pattern source and the downstream data mover.
// Signals : tdata  - stream data word (DATA_W bits), driven by the master
//           tvalid - beat valid, driven by the master
//           tlast  - final beat of a frame, driven by the master
//           tready - downstream ready, driven by the slave
// Modports: master (pattern source side), slave (consumer side)
// ---------------------------------------------------------------------------
interface axi_stream_pattern_source_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axi_stream_pattern_source.sv
// ---------------------------------------------------------------------------
// axi_stream_pattern_source
// Purpose : Emits frames of incrementing data words on an AXI4-Stream style
//           master port. A frame is requested with start; seed, length and
//           gap are captured when the request is accepted. Successive beats
//           carry seed, seed+1, ... (wrapping modulo 2^DATA_W), tlast marks
//           the final beat, and an optional number of idle cycles can be
//           inserted between beats.
// Ports   : clk    - single clock, rising edge
//           reset  - synchronous, active-high
//           start  - frame request, honoured only while idle
//           seed   - first data word of the frame
//           length - beats per frame (0 means the request is ignored)
//           gap    - idle cycles between beats
//           busy   - frame in progress
//           done   - one-cycle pulse after the final beat transfers
//           m_axis - stream master (tdata/tvalid/tlast out, tready in)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame; waits for start with a non-zero length
// SEND  | beat presented with tvalid=1, held until tready handshake
// GAP   | tvalid=0 for the latched number of idle cycles between beats
// ---------------------------------------------------------------------------
module axi_stream_pattern_source #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_W-1:0]            seed,
    input  logic [LEN_W-1:0]             length,
    input  logic [3:0]                   gap,
    output logic                         busy,
    output logic                         done,
    axi_stream_pattern_source_if.master  m_axis
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state;

    logic [LEN_W-1:0]  len_q;
    logic [3:0]        gap_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [3:0]        gap_cnt;

    logic [DATA_W-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;

    logic [LEN_W-1:0]  last_idx;
    logic [LEN_W-1:0]  beat_nxt;
    logic              handshake;

    // len_q is never zero while a frame runs, so last_idx never underflows.
    assign last_idx  = len_q - LEN_W'(1);
    assign beat_nxt  = beat_cnt + LEN_W'(1);
    assign handshake = tvalid_q & m_axis.tready;

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            gap_q    <= '0;
            beat_cnt <= '0;
            gap_cnt  <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The first beat is presented on the accepting edge,
                    // so a start during the done cycle chains frames with
                    // no dead cycle.
                    if (start && (length != '0)) begin
                        state    <= ST_SEND;
                        len_q    <= length;
                        gap_q    <= gap;
                        beat_cnt <= '0;
                        gap_cnt  <= '0;
                        tdata_q  <= seed;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (length == LEN_W'(1));
                        busy     <= 1'b1;
                    end
                end

                ST_SEND: begin
                    if (handshake) begin
                        if (beat_cnt == last_idx) begin
                            state    <= ST_IDLE;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            beat_cnt <= beat_nxt;
                            tdata_q  <= tdata_q + DATA_W'(1);
                            if (gap_q == 4'd0) begin
                                tlast_q <= (beat_nxt == last_idx);
                            end else begin
                                state    <= ST_GAP;
                                tvalid_q <= 1'b0;
                                tlast_q  <= 1'b0;
                                gap_cnt  <= gap_q;
                            end
                        end
                    end
                end

                ST_GAP: begin
                    // Down-counter loaded with the gap on entry; the edge
                    // that sees terminal count 1 is the G-th idle edge and
                    // re-presents the (already incremented) next beat.
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt == 4'd1) begin
                        state    <= ST_SEND;
                        tvalid_q <= 1'b1;
                        tlast_q  <= (beat_cnt == last_idx);
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    tvalid_q <= 1'b0;
                    tlast_q  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
